fetch_unit: RTL

- Instruction fetch stage, directly upstream of the decode/control unit.
- Generates sequential instruction addresses and issues them to instruction memory over a ready/valid request channel with in-order responses.
- Buffers returned instructions in a DEPTH-entry prefetch FIFO and presents the head to decode, including the packed 15-bit control field {instr[31:25], instr[14:12], instr[6:2]}.
- Handles decode back-pressure (stall) and branch/jump redirects, and discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential address generation, in-order
// imem request channel, prefetch FIFO and redirect/flush handling.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [14:0] control_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_pc;
    logic          handshake;
    logic          resp_seen;
    logic          push;
    logic          pop;

    // Credit uses registered counts only, so a pop frees a slot a cycle later
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign redirect_pc = redirect_addr_i & 32'hFFFF_FFFC;

    assign imem_req_o  = !reset_i && !redirect_i && (credit_used < DEPTH_W);
    assign imem_addr_o = fetch_pc;
    assign handshake   = imem_req_o && imem_ready_i;

    // A response with nothing outstanding is ignored entirely
    assign resp_seen = imem_rvalid_i && (inflight != '0);
    assign push      = resp_seen && (discard == '0) && !redirect_i;

    assign valid_o   = !reset_i && (fifo_count != '0);
    assign pop       = valid_o && !stall_i && !redirect_i;

    assign instr_o   = valid_o ? instr_q[rd_ptr] : NOP;
    assign pc_o      = valid_o ? pc_q[rd_ptr] : 32'h0;
    assign control_o = {instr_o[31:25], instr_o[14:12], instr_o[6:2]};

    // FIFO storage: written on push, never needs clearing
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_q[wr_ptr] <= imem_rdata_i;
            pc_q[wr_ptr]    <= resp_pc;
        end
    end

    // Fetch PC, response tracking, FIFO pointers and flush bookkeeping
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc   <= RESET_ADDR;
            resp_pc    <= RESET_ADDR;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            inflight   <= '0;
            discard    <= '0;
        end else if (redirect_i) begin
            // Everything outstanding becomes stale; a response landing now is dropped
            fetch_pc   <= redirect_pc;
            resp_pc    <= redirect_pc;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            inflight   <= inflight - CW'(resp_seen);
            discard    <= inflight - CW'(resp_seen);
        end else begin
            if (handshake) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight <= inflight + CW'(handshake) - CW'(resp_seen);
            if (resp_seen && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

endmodule
